// File: rtl/dlsc_pxdma_pkg.sv
// Shared constants for the pxdma unpacker: bytes-per-pixel codes, FSM states, buffer depth.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dlsc_pxdma_pkg;

    // cmd_bpw encodings: bytes per pixel minus one
    localparam logic [1:0] BPW_1B = 2'd0;
    localparam logic [1:0] BPW_2B = 2'd1;
    localparam logic [1:0] BPW_3B = 2'd2;
    localparam logic [1:0] BPW_4B = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } st_t;

    localparam int BUF_BYTES = 8;

    // Number of bytes in one pixel for a given bpw code (1..4)
    function automatic logic [2:0] bpw_bytes(input logic [1:0] bpw);
        return {1'b0, bpw} + 3'd1;
    endfunction

endpackage

// File: rtl/dlsc_pxdma_bytebuf.sv
// 8-byte shift buffer: pushes 1..4 bytes of a word (skipping leading bytes), pops 1..4 from the low end.
// Latency: push/pop take effect at the next clock; head/count are registered.
// Backpressure: none internally; the caller must never push more than fits after this cycle's pop.
module dlsc_pxdma_bytebuf
    import dlsc_pxdma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push_en,
    input  logic [1:0]  push_skip,
    input  logic [31:0] push_data,
    input  logic        pop_en,
    input  logic [1:0]  pop_bpw,
    output logic [3:0]  count,
    output logic [31:0] head
);

    logic [BUF_BYTES-1:0][7:0] mem;
    logic [BUF_BYTES-1:0][7:0] mem_nxt;
    logic [3:0]                count_nxt;
    logic [3:0]                pop_n;
    logic [3:0]                push_n;
    logic [3:0]                base;
    logic [31:0]               pd;

    assign head = mem[3:0];

    // Shift out popped bytes, then append pushed bytes right after the survivors
    always_comb begin
        pop_n   = pop_en  ? ({2'b00, pop_bpw} + 4'd1) : 4'd0;
        push_n  = push_en ? (4'd4 - {2'b00, push_skip}) : 4'd0;
        base    = count - pop_n;
        pd      = push_data >> {push_skip, 3'b000};
        mem_nxt = '0;
        for (int i = 0; i < BUF_BYTES; i++) begin
            for (int j = 0; j <= 4; j++) begin
                if (int'(pop_n) == j && (i + j) < BUF_BYTES) begin
                    mem_nxt[i] = mem[i + j];
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            for (int d = 0; d < BUF_BYTES; d++) begin
                if (j < int'(push_n) && (int'(base) + j) == d) begin
                    mem_nxt[d] = pd[8*j +: 8];
                end
            end
        end
        count_nxt = flush ? 4'd0 : (count + push_n - pop_n);
    end

    // Buffer storage and fill level
    always_ff @(posedge clk) begin
        if (rst) begin
            mem   <= '0;
            count <= 4'd0;
        end else begin
            mem   <= mem_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/dlsc_pxdma_unpacker.sv
// Row unpacker: turns 32-bit little-endian read words into right-aligned 1..4 byte pixels, flagging the row's last.
// Latency: a pixel is registered one clock after enough bytes sit in the byte buffer.
// Backpressure: px_ready stalls the pixel register; in_ready drops when the buffer cannot take a full word.
// Build option: DLSC_PXDMA_UNPACKER_SWAP_EN reverses byte order within each pixel.
module dlsc_pxdma_unpacker
    import dlsc_pxdma_pkg::*;
#(
    parameter int XBITS = 12,
    parameter int WLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             cmd_ready,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_offset,
    input  logic [1:0]       cmd_bpw,
    input  logic [XBITS-1:0] cmd_words,
    output logic             in_ready,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             px_ready,
    output logic             px_valid,
    output logic [31:0]      px_data,
    output logic             px_last
);

    generate
        if (WLEN != 32) begin : g_wlen_chk
            $error("dlsc_pxdma_unpacker: WLEN must be 32");
        end
    endgenerate

    st_t              state, state_nxt;
    logic             ready_en;
    logic [XBITS-1:0] px_cnt;
    logic [XBITS+2:0] word_cnt;
    logic [XBITS+2:0] row_bytes;
    logic [XBITS+2:0] row_words;
    logic [1:0]       bpw_r;
    logic [1:0]       skip_r;
    logic [3:0]       buf_count;
    logic [31:0]      buf_head;
    logic [3:0]       need_bytes;
    logic [3:0]       avail_after;
    logic [31:0]      px_fmt;
    logic             cmd_acc;
    logic             push;
    logic             pop;
    logic             done;

    assign cmd_acc    = cmd_valid && cmd_ready;
    assign push       = in_valid && in_ready;
    assign need_bytes = {1'b0, bpw_bytes(bpw_r)};
    assign pop        = (state == ST_RUN) && (px_cnt != '0) && (!px_valid || px_ready)
                        && (buf_count >= need_bytes);
    assign avail_after = buf_count - (pop ? need_bytes : 4'd0);
    // The last pixel load always follows the row's final word, so the row ends here
    assign done       = pop && (px_cnt == XBITS'(1));
    assign row_bytes  = ({3'b000, cmd_words} * {{XBITS{1'b0}}, bpw_bytes(cmd_bpw)})
                        + {{(XBITS+1){1'b0}}, cmd_offset};
    assign row_words  = (row_bytes + (XBITS+3)'(3)) >> 2;

    dlsc_pxdma_bytebuf u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (done),
        .push_en   (push),
        .push_skip (skip_r),
        .push_data (in_data),
        .pop_en    (pop),
        .pop_bpw   (bpw_r),
        .count     (buf_count),
        .head      (buf_head)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: empty rows never leave IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_acc && cmd_words != '0) state_nxt = ST_RUN;
            ST_RUN:  if (done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake readies
    always_comb begin
        cmd_ready = ready_en && (state == ST_IDLE);
        in_ready  = (state == ST_RUN) && (word_cnt != '0) && (avail_after <= 4'd4);
    end

    // Select pixel bytes from the buffer head, zeroing unused upper bytes
    always_comb begin
        px_fmt = '0;
        for (int k = 0; k < 4; k++) begin
`ifdef DLSC_PXDMA_UNPACKER_SWAP_EN
            for (int j = 0; j < 4; j++) begin
                if (k <= int'(bpw_r) && j == int'(bpw_r) - k) px_fmt[8*k +: 8] = buf_head[8*j +: 8];
            end
`else
            if (k <= int'(bpw_r)) px_fmt[8*k +: 8] = buf_head[8*k +: 8];
`endif
        end
    end

    // Row counters, command latch and pixel output register
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en <= 1'b0;
            px_cnt   <= '0;
            word_cnt <= '0;
            bpw_r    <= BPW_1B;
            skip_r   <= 2'd0;
            px_valid <= 1'b0;
            px_data  <= '0;
            px_last  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (cmd_acc) begin
                px_cnt   <= cmd_words;
                word_cnt <= row_words;
                bpw_r    <= cmd_bpw;
                skip_r   <= cmd_offset;
            end else begin
                if (push) begin
                    word_cnt <= word_cnt - 1'b1;
                    skip_r   <= 2'd0;
                end
                if (pop) px_cnt <= px_cnt - 1'b1;
            end
            if (pop) begin
                px_valid <= 1'b1;
                px_data  <= px_fmt;
                px_last  <= (px_cnt == XBITS'(1));
            end else if (px_ready) begin
                px_valid <= 1'b0;
                px_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dlsc_pxdma_unpacker.sv
// Bench for dlsc_pxdma_unpacker: fixed vectors, corner sequences and random rows against a byte-stream model.
// Latency: not applicable.
// Backpressure: exercised with constant, toggling and random px_ready / in_valid.
module tb_dlsc_pxdma_unpacker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_ready;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_offset = 2'd0;
    logic [1:0]  cmd_bpw = 2'd0;
    logic [11:0] cmd_words = 12'd0;
    logic        in_ready;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        px_ready = 1'b0;
    logic        px_valid;
    logic [31:0] px_data;
    logic        px_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] in_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dlsc_pxdma_unpacker #(.XBITS(12), .WLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_offset (cmd_offset),
        .cmd_bpw    (cmd_bpw),
        .cmd_words  (cmd_words),
        .in_ready   (in_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .px_ready   (px_ready),
        .px_valid   (px_valid),
        .px_data    (px_data),
        .px_last    (px_last)
    );

    typedef struct packed {
        logic [1:0]        off;
        logic [1:0]        bpw;
        logic [7:0]        npx;
        logic [7:0]        nw;
        logic [2:0][31:0]  w;
        logic [3:0][31:0]  px;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] off, input logic [1:0] bpw, input int npx, input int nw,
                                input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                                input logic [31:0] p3);
        vec_t v;
        v.off = off; v.bpw = bpw; v.npx = npx[7:0]; v.nw = nw[7:0];
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.px[0] = p0; v.px[1] = p1; v.px[2] = p2; v.px[3] = p3;
        return v;
    endfunction

    // Expected values are written in memory byte order; the swap build reverses each pixel's bytes
    function automatic logic [31:0] sw(input logic [31:0] v, input logic [1:0] bpw);
        logic [31:0] r;
        r = v;
`ifdef DLSC_PXDMA_UNPACKER_SWAP_EN
        r = 32'h0;
        for (int k = 0; k <= int'(bpw); k++) r[8*(int'(bpw)-k) +: 8] = v[8*k +: 8];
`endif
        return r;
    endfunction

    // Reference model: flatten words to a byte stream, drop the offset, cut fixed-size pixels
    task automatic model(input logic [1:0] off, input logic [1:0] bpw, input int npx, input logic [31:0] words[$]);
        logic [7:0]  bq[$];
        logic [31:0] val;
        logic [7:0]  b;
        exp_q.delete();
        foreach (words[i]) for (int k = 0; k < 4; k++) bq.push_back(words[i][8*k +: 8]);
        for (int k = 0; k < int'(off); k++) void'(bq.pop_front());
        for (int p = 0; p < npx; p++) begin
            val = 32'h0;
            for (int k = 0; k <= int'(bpw); k++) begin
                b = bq.pop_front();
`ifdef DLSC_PXDMA_UNPACKER_SWAP_EN
                val = (val << 8) | {24'h0, b};
`else
                val = val | ({24'h0, b} << (8*k));
`endif
            end
            exp_q.push_back(val);
        end
    endtask

    task automatic prep_rand(input logic [1:0] off, input logic [1:0] bpw, input int npx, output int nw);
        logic [31:0] words[$];
        nw = (int'(off) + npx * (int'(bpw) + 1) + 3) / 4;
        for (int i = 0; i < nw; i++) words.push_back($urandom);
        model(off, bpw, npx, words);
        in_q = words;
        in_q.push_back($urandom);
        in_q.push_back($urandom);
    endtask

    task automatic run_row(input logic [1:0] off, input logic [1:0] bpw, input int npx, input int nw,
                           input int rdy_mode, input int vld_mode, input int stop_at);
        int got, acc, cyc;
        logic stall, ok;
        logic [31:0] prev;
        got = 0; acc = 0; cyc = 0; stall = 1'b0; ok = 1'b0; prev = 32'h0;
        @(negedge clk);
        in_valid = 1'b0; px_ready = 1'b0;
        cmd_valid = 1'b1; cmd_offset = off; cmd_bpw = bpw; cmd_words = npx[11:0];
        while (!ok && cyc < 50) begin
            #1 ok = cmd_ready;
            @(posedge clk);
            cyc++;
            if (!ok) @(negedge clk);
        end
        if (!ok) begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
            @(negedge clk); cmd_valid = 1'b0;
            return;
        end
        cyc = 0;
        while (got < stop_at && cyc < 3000) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            in_valid = (in_q.size() != 0) && (vld_mode == 0 || $urandom_range(0, 3) != 0);
            in_data  = (in_q.size() != 0) ? in_q[0] : 32'h0;
            case (rdy_mode)
                0:       px_ready = 1'b1;
                1:       px_ready = cyc[0];
                default: px_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (stall) begin
                chk("hold_valid", {31'h0, px_valid}, 32'd1);
                chk("hold_data", px_data, prev);
            end
            if (in_valid && in_ready) begin
                void'(in_q.pop_front());
                acc++;
            end
            if (px_valid && px_ready) begin
                chk("px_data", px_data, exp_q[got]);
                chk("px_last", {31'h0, px_last}, {31'h0, (got == npx - 1)});
                got++;
            end
            stall = px_valid && !px_ready;
            prev  = px_data;
            @(posedge clk);
            cyc++;
        end
        if (got < stop_at) chk("row_timeout_pixels", got, stop_at);
        else if (stop_at == npx) chk("words_accepted", acc, nw);
        @(negedge clk);
        in_valid = 1'b0; px_ready = 1'b0;
    endtask

    initial begin
        vec_t tbl[5];
        int   nw;
        logic [1:0] ro, rb;
        int   rn;

        tbl[0] = mk(2'd0, 2'd2, 4, 3, 32'h44332211, 32'h88776655, 32'hCCBBAA99,
                    32'h00332211, 32'h00665544, 32'h00998877, 32'h00CCBBAA);
        tbl[1] = mk(2'd1, 2'd1, 2, 2, 32'h44332211, 32'h88776655, 32'h0,
                    32'h00003322, 32'h00005544, 32'h0, 32'h0);
        tbl[2] = mk(2'd0, 2'd0, 4, 1, 32'h04030201, 32'h0, 32'h0,
                    32'h01, 32'h02, 32'h03, 32'h04);
        tbl[3] = mk(2'd2, 2'd3, 2, 3, 32'h44332211, 32'h88776655, 32'hCCBBAA99,
                    32'h66554433, 32'hAA998877, 32'h0, 32'h0);
        tbl[4] = mk(2'd3, 2'd0, 2, 2, 32'h44332211, 32'h88776655, 32'h0,
                    32'h44, 32'h55, 32'h0, 32'h0);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_px_valid", {31'h0, px_valid}, 32'd0);
        chk("rst_px_data", px_data, 32'd0);
        chk("rst_px_last", {31'h0, px_last}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);

        // Fixed vectors
        for (int t = 0; t < 5; t++) begin
            in_q.delete(); exp_q.delete();
            for (int w = 0; w < int'(tbl[t].nw); w++) in_q.push_back(tbl[t].w[w]);
            in_q.push_back(32'hDEADBEEF);
            in_q.push_back(32'hFEEDF00D);
            for (int p = 0; p < int'(tbl[t].npx); p++) exp_q.push_back(sw(tbl[t].px[p], tbl[t].bpw));
            run_row(tbl[t].off, tbl[t].bpw, int'(tbl[t].npx), int'(tbl[t].nw), 0, 0, int'(tbl[t].npx));
        end

        // Empty row: accepted, no output, still IDLE
        @(negedge clk);
        cmd_valid = 1'b1; cmd_offset = 2'd1; cmd_bpw = 2'd0; cmd_words = 12'd0;
        in_valid = 1'b1; in_data = 32'h12345678;
        #1 chk("zero_cmd_ready", {31'h0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        #1;
        chk("zero_in_ready", {31'h0, in_ready}, 32'd0);
        chk("zero_px_valid", {31'h0, px_valid}, 32'd0);
        chk("zero_still_idle", {31'h0, cmd_ready}, 32'd1);
        in_valid = 1'b0;
        prep_rand(2'd0, 2'd0, 5, nw);
        run_row(2'd0, 2'd0, 5, nw, 0, 0, 5);

        // 4-byte pixels with px_ready toggling every cycle
        prep_rand(2'd0, 2'd3, 8, nw);
        run_row(2'd0, 2'd3, 8, nw, 1, 0, 8);

        // Reset in the middle of a row
        prep_rand(2'd0, 2'd0, 8, nw);
        run_row(2'd0, 2'd0, 8, nw, 0, 0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cmd_ready", {31'h0, cmd_ready}, 32'd0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("midrst_px_valid", {31'h0, px_valid}, 32'd0);
        chk("midrst_px_data", px_data, 32'd0);
        chk("midrst_px_last", {31'h0, px_last}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk("midrst_recover_ready", {31'h0, cmd_ready}, 32'd1);
        prep_rand(2'd0, 2'd0, 4, nw);
        run_row(2'd0, 2'd0, 4, nw, 0, 0, 4);

        // Random rows with random stalls on both sides
        for (int r = 0; r < 40; r++) begin
            ro = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            rn = $urandom_range(1, 20);
            prep_rand(ro, rb, rn, nw);
            run_row(ro, rb, rn, nw, (r % 3 == 0) ? 0 : 2, (r % 2), rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
